// File: rtl/jk_bank_ctrl_if.sv
// Command channel between the lab-board control logic and jk_bank_ctrl.
// The master offers a command; the controller (slave) signals readiness.
interface jk_bank_ctrl_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic             Cmd_valid;
  logic             Cmd_ready;
  logic [2:0]       Cmd_op;
  logic [W-1:0]     Cmd_data;
  logic [CNT_W-1:0] Cmd_steps;

  modport master (
    output Cmd_valid,
    output Cmd_op,
    output Cmd_data,
    output Cmd_steps,
    input  Cmd_ready
  );

  modport slave (
    input  Cmd_valid,
    input  Cmd_op,
    input  Cmd_data,
    input  Cmd_steps,
    output Cmd_ready
  );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Sequencer for a bank of W 74HC112-style JK flip-flops sharing Clk.
// One accepted command becomes per-cycle J/K drive plus active-low preset and
// clear strobes. Counting J/K terms are formed from the bank's Q read-back.
// All bank-facing outputs depend only on registered state and Q_fb.
module jk_bank_ctrl #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic                Clk,
  input  logic                Rd,
  jk_bank_ctrl_if.slave       cmd,
  input  logic [W-1:0]        Q_fb,
  output logic [W-1:0]        J,
  output logic [W-1:0]        K,
  output logic                Sd_n,
  output logic                Rd_n,
  output logic                Busy,
  output logic                Done,
  output logic                Wrap
);

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_CLEAR  = 3'd2,
    OP_PRESET = 3'd3,
    OP_UP     = 3'd4,
    OP_DOWN   = 3'd5,
    OP_TOGGLE = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLR,
    S_PRE,
    S_RUN,
    S_FIN
  } state_e;

  state_e           state, state_nxt;
  op_e              op_q;
  logic [W-1:0]     data_q;
  logic [CNT_W-1:0] step_cnt;
  logic             done_q;
  logic             wrap_q;

  logic             accept;
  logic             wrap_now;
  logic [W-1:0]     up_term;
  logic [W-1:0]     dn_term;

  assign accept = cmd.Cmd_valid && (state == S_IDLE);

  // A counting step wraps when UP leaves all-ones or DOWN leaves all-zeros.
  assign wrap_now = (state == S_RUN) &&
                    (((op_q == OP_UP) && (&Q_fb)) || ((op_q == OP_DOWN) && (~|Q_fb)));

  // Next-state decode: dispatch on the accepted op, single-cycle states fall to FIN.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op_e'(cmd.Cmd_op))
            OP_LOAD:   state_nxt = S_LOAD;
            OP_CLEAR:  state_nxt = S_CLR;
            OP_PRESET: state_nxt = S_PRE;
            OP_UP, OP_DOWN, OP_TOGGLE:
              state_nxt = (cmd.Cmd_steps != '0) ? S_RUN : S_FIN;
            default:   state_nxt = S_FIN;
          endcase
        end
      end
      S_LOAD, S_CLR, S_PRE: state_nxt = S_FIN;
      S_RUN:  if (step_cnt == CNT_W'(1)) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control registers: state, step counter and the Done/Wrap pulses.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (Rd) begin
      state    <= S_IDLE;
      step_cnt <= '0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state_nxt == S_FIN);
      wrap_q <= wrap_now;
      if (accept)
        step_cnt <= cmd.Cmd_steps;
      else if (state == S_RUN)
        step_cnt <= step_cnt - CNT_W'(1);
    end
  end

  // Command capture: op and data are only consumed outside IDLE, after a capture.
  always_ff @(posedge Clk) begin
    // NOTE: these datapath registers have no reset; they are always written before being used.
    if (accept) begin
      op_q   <= op_e'(cmd.Cmd_op);
      data_q <= cmd.Cmd_data;
    end
  end

  // Synchronous-counter terms: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic carry_up;
    logic carry_dn;
    carry_up = 1'b1;
    carry_dn = 1'b1;
    up_term  = '0;
    dn_term  = '0;
    for (int i = 0; i < W; i++) begin
      up_term[i] = carry_up;
      dn_term[i] = carry_dn;
      carry_up   = carry_up & Q_fb[i];
      carry_dn   = carry_dn & ~Q_fb[i];
    end
  end

  // Bank drive: hold by default, strobe or steer J/K according to the state.
  always_comb begin
    J    = '0;
    K    = '0;
    Sd_n = 1'b1;
    Rd_n = 1'b1;
    case (state)
      S_LOAD: begin
        J = data_q;
        K = ~data_q;
      end
      S_CLR: Rd_n = 1'b0;
      S_PRE: Sd_n = 1'b0;
      S_RUN: begin
        case (op_q)
          OP_UP: begin
            J = up_term;
            K = up_term;
          end
          OP_DOWN: begin
            J = dn_term;
            K = dn_term;
          end
          OP_TOGGLE: begin
            J = '1;
            K = '1;
          end
          default: begin
            J = '0;
            K = '0;
          end
        endcase
      end
      default: begin
        J = '0;
        K = '0;
      end
    endcase
  end

  assign Busy          = (state != S_IDLE);
  assign cmd.Cmd_ready = (state == S_IDLE);
  assign Done          = done_q;
  assign Wrap          = wrap_q;

endmodule

// File: doc/jk_bank_ctrl.md
Name: jk_bank_ctrl

Overview:
- Command-driven sequencer for a bank of W 74HC112-style JK flip-flops. All flip-flops share Clk.
- Translates one accepted command (load, clear, preset, count up/down, toggle N steps) into per-cycle J/K drive and active-low preset/clear strobes.
- Reads the bank's Q outputs back to form synchronous-counter J/K terms.
- Sits between the lab-board control logic and the flip-flop bank. The bank is the only resource it sequences.

Parameters:
- W, 4, number of JK flip-flops in the bank.
- CNT_W, 8, width of the step counter for counting commands.

Ports:
- Clk  in  1  single system clock; rising edge. Bank flip-flops use the same edge.
- Rd  in  1  reset: synchronous, active-high.
- Cmd_valid  in  1  command present.
- Cmd_ready  out  1  controller can accept a command.
- Cmd_op  in  3  0 NOP, 1 LOAD, 2 CLEAR, 3 PRESET, 4 UP, 5 DOWN, 6 TOGGLE, 7 reserved.
- Cmd_data  in  W  LOAD value.
- Cmd_steps  in  CNT_W  number of clock steps for UP/DOWN/TOGGLE.
- Q_fb  in  W  Q outputs of the bank.
- J  out  W  J inputs to the bank.
- K  out  W  K inputs to the bank.
- Sd_n  out  1  shared active-low preset to the bank.
- Rd_n  out  1  shared active-low clear to the bank.
- Busy  out  1  command executing.
- Done  out  1  one-cycle pulse when a command completes.
- Wrap  out  1  one-cycle pulse when a count step wraps (UP from all-ones, DOWN from all-zeros).

Behaviour:
- States: IDLE, LOAD, CLR, PRE, RUN, FIN. State, step counter, op, data, Done and Wrap are registers. J, K, Sd_n, Rd_n, Cmd_ready and Busy are combinational from registered state and Q_fb only; there is no path from Cmd_* to the outputs.
- Reset (Rd=1 at a rising edge):
  - state=IDLE, step counter=0, Done=0, Wrap=0.
  - Outputs therefore: J=0, K=0, Sd_n=1, Rd_n=1, Busy=0, Cmd_ready=1.
  - Bank contents are not modified by reset.
  - Reset mid-command aborts immediately. No Done pulse is produced.
- Acceptance:
  - Cmd_ready=1 only in IDLE.
  - A command is accepted on an edge with Cmd_valid && Cmd_ready. Op, data and steps are captured.
  - Next state:
    - NOP or 7 → FIN.
    - LOAD → LOAD.
    - CLEAR → CLR.
    - PRESET → PRE.
    - UP/DOWN/TOGGLE with steps≠0 → RUN.
    - UP/DOWN/TOGGLE with steps=0 → FIN.
- IDLE: J=K=0 (hold), Sd_n=Rd_n=1, Busy=0.
- LOAD (1 cycle):
  - J=data, K=~data, so the bank equals data after the edge.
  - → FIN.
- CLR (1 cycle):
  - Rd_n=0, J=K=0.
  - → FIN.
- PRE (1 cycle):
  - Sd_n=0, J=K=0.
  - → FIN.
- RUN: each cycle is one bank step. The step counter decrements at each edge; leave RUN on the edge where the counter goes 1→0, → FIN.
  - UP: J[i]=K[i]=AND(Q_fb[i-1:0]), with bit 0 always 1.
  - DOWN: J[i]=K[i]=AND(~Q_fb[i-1:0]), with bit 0 always 1.
  - TOGGLE: J=K=all ones.
  - Wrap is registered and pulses on the cycle after an edge where (UP && Q_fb all ones) or (DOWN && Q_fb all zeros). It can pulse multiple times within one command.
- FIN (1 cycle):
  - J=K=0, Busy=1.
  - Done=1 during this cycle (registered on entry).
  - → IDLE.
- Busy=1 in every state except IDLE.
- Sd_n and Rd_n are never low in the same cycle.
- A count wraps modulo 2^W.
- Command latency, accept edge to Done: LOAD/CLEAR/PRESET take 2 cycles. Counting commands take steps+1 cycles. NOP/reserved/steps=0 take 1 cycle.
- Cmd_valid held while not ready is ignored. Commands are not queued.

Test Plan:
- Reset, then LOAD data=4'b1010 → next cycle J=1010, K=0101; bank reads 1010; Done pulses one cycle later; Cmd_ready returns 1.
- From bank=4'b1101, UP steps=5 → bank sequence 1110, 1111, 0000, 0001, 0010; exactly one Wrap pulse (after 1111→0000); Done at cycle 6 after accept.
- From bank=4'b0001, DOWN steps=3 → bank 0000, 1111, 1110; one Wrap; final Q_fb=1110.
- CLEAR then PRESET back-to-back → Rd_n low exactly 1 cycle, then bank=0000; Sd_n low exactly 1 cycle, then bank=1111; Sd_n and Rd_n never simultaneously 0.
- UP steps=0 and op=7 → Done one cycle after accept, J=K=0 throughout, bank unchanged.
- UP steps=200, assert Rd at step 10 → next cycle J=K=0, Busy=0, Cmd_ready=1, no Done pulse; bank holds its value at abort; Cmd_valid while Busy=1 is ignored.
